// File: rtl/load_store_unit.sv
// Load/store sequencer between the RV32E execute stage and the byte-banked data memory group.
// Store 2 cycles, load 4 cycles, fault 1 cycle to resp_valid; one request at a time, held until resp_ready.
module load_store_unit #(
  parameter int DATA_DEPTH = 4096,
  localparam int ADDR_W = 2 + $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [3:0]        mem_write_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD0, S_RD1, S_RD2, S_RESP, S_RESP_F
  } state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_funct3;
  logic [3:0]        r_mem_mask;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_resp_valid, r_resp_fault;
  logic [31:0]       r_resp_rdata;

  logic [2:0]        w_size;
  logic [3:0]        w_mask;
  logic [ADDR_W:0]   w_end;
  logic              w_f3_ok, w_range_ok, w_fault;
  logic [31:0]       w_ext;

  // One extra bit on w_end so an access ending exactly at the top of memory is still legal.
  always_comb begin
    w_size = 3'd1;
    w_mask = 4'b0001;
    case (req_funct3[1:0])
      2'b01:   begin w_size = 3'd2; w_mask = 4'b0011; end
      2'b10:   begin w_size = 3'd4; w_mask = 4'b1111; end
      default: ;
    endcase
    w_f3_ok    = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (!req_write && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
    w_end      = {1'b0, req_addr[ADDR_W-1:0]} + {{(ADDR_W-2){1'b0}}, w_size};
    w_range_ok = (req_addr[31:ADDR_W] == '0) && (w_end <= {1'b1, {ADDR_W{1'b0}}});
    w_fault    = !(w_f3_ok && w_range_ok);
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      3'b001:  w_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b100:  w_ext = {24'd0, mem_read_data[7:0]};
      3'b101:  w_ext = {16'd0, mem_read_data[15:0]};
      default: w_ext = mem_read_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_fault ? S_RESP_F : (req_write ? S_WRITE : S_RD0);
      S_WRITE:  w_next = S_RESP;
      S_RD0:    w_next = S_RD1;
      S_RD1:    w_next = S_RD2;
      S_RD2:    w_next = S_RESP;
      S_RESP,
      S_RESP_F: if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // mem_addr is only written on a non-faulting accept, so it stays put through RD0..RD2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3     <= 3'd0;
      r_mem_mask   <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_funct3 <= req_funct3;
          if (w_fault) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_rdata <= 32'd0;
          end else begin
            r_mem_addr <= req_addr[ADDR_W-1:0];
            if (req_write) begin
              r_mem_mask  <= w_mask;
              r_mem_wdata <= req_wdata;
            end
          end
        end
        S_WRITE: begin
          r_mem_mask   <= 4'd0;
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        S_RD2: begin
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= w_ext;
        end
        S_RESP, S_RESP_F: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = r_resp_valid;
  assign resp_fault     = r_resp_fault;
  assign resp_rdata     = r_resp_rdata;
  assign mem_write_mask = r_mem_mask;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-during-store sequence and random traffic
// against a byte-array reference model, with a 2-cycle-latency rotating memory group model.
module tb_load_store_unit;
  localparam int AW   = 14;
  localparam int MEMB = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_DEPTH(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_write_mask(mem_write_mask), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory group model: mask and data are relative to mem_addr, lanes wrap at the top.
  logic [7:0]  mem [MEMB];
  logic [31:0] rd_p1, rd_p2;
  bit          mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEMB; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_mask[i]) mem[AW'(mem_addr + AW'(i))] <= mem_write_data[8*i +: 8];
        rd_p1[8*i +: 8] <= mem[AW'(mem_addr + AW'(i))];
      end
    end
    rd_p2 <= rd_p1;
  end
  assign mem_read_data = rd_p2;

  logic [7:0] ref_mem [MEMB];
  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic void ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic flt,
                                    output logic [31:0] rd, output int lat);
    int sz;
    logic legal;
    longint last;
    logic [31:0] raw;
    sz    = nbytes(f3);
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
    last  = longint'({32'd0, addr}) + longint'(sz);
    flt   = !legal || (last > longint'(MEMB));
    rd    = 32'd0;
    raw   = 32'd0;
    if (flt) lat = 1;
    else if (wr) begin
      for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      lat = 2;
    end else begin
      for (int i = 0; i < sz; i++) raw[8*i +: 8] = ref_mem[int'(addr) + i];
      rd = raw;
      if (f3 == 3'd0 && raw >= 32'h80)   rd = raw - 32'h100;
      if (f3 == 3'd1 && raw >= 32'h8000) rd = raw - 32'h10000;
      lat = 4;
    end
  endfunction

  task automatic xact(input string nm, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_flt, input logic [31:0] exp_rd,
                      input int exp_lat, input int hold, input logic early);
    logic [AW-1:0] addr_before;
    logic [3:0]    mask_seen;
    logic [31:0]   wd_seen;
    int            cyc, mask_cycles;
    logic          got;
    @(negedge clk);
    check({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
    addr_before = mem_addr;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = early && (hold == 0);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; got = 1'b0; mask_cycles = 0; mask_seen = 4'd0; wd_seen = 32'd0;
    while (cyc <= 12 && !got) begin
      if (mem_write_mask != 4'd0) begin
        mask_cycles++; mask_seen = mem_write_mask; wd_seen = mem_write_data;
      end
      if (!wr && !exp_flt && cyc <= 3) check({nm, " mem_addr held"}, 32'(mem_addr), 32'(addr[AW-1:0]));
      if (resp_valid) got = 1'b1;
      else begin cyc++; @(negedge clk); end
    end
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    check({nm, " rdata"}, resp_rdata, exp_rd);
    check({nm, " fault"}, 32'(resp_fault), 32'(exp_flt));
    check({nm, " mask cycles"}, 32'(mask_cycles), (wr && !exp_flt) ? 32'd1 : 32'd0);
    if (wr && !exp_flt) begin
      check({nm, " mask value"}, 32'(mask_seen), 32'((1 << nbytes(f3)) - 1));
      check({nm, " write data"}, wd_seen, wdata);
    end
    if (exp_flt) check({nm, " no mem addr change"}, 32'(mem_addr), 32'(addr_before));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, " hold valid"}, 32'(resp_valid), 32'd1);
      check({nm, " hold rdata"}, resp_rdata, exp_rd);
      check({nm, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check({nm, " valid cleared"}, 32'(resp_valid), 32'd0);
    check({nm, " back to idle"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rd;
    logic        exp_flt;
    int          exp_lat, hold;
    logic        early;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic        m_flt;
    logic [31:0] m_rd;
    int          m_lat;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          hold;
    logic        any_resp;

    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'(i * 7 + 3);

    tbl.push_back('{1'b1, 3'd2, 32'h100,      32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0, 4, 5, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h203,      32'h00008001, 32'h0,        1'b0, 2, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h203,      32'h0,        32'hFFFF8001, 1'b0, 4, 0, 1'b1});
    tbl.push_back('{1'b0, 3'd5, 32'h203,      32'h0,        32'h00008001, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h203,      32'h0,        32'h00000001, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h3FFC,     32'h12345678, 32'h0,        1'b0, 2, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h3FFC,     32'h0,        32'h12345678, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h3FFD,     32'h0,        32'h0,        1'b1, 1, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h3FFF,     32'h0,        32'h00000012, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h3FFF,     32'h0,        32'h0,        1'b1, 1, 0, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h4000,     32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'h100,      32'h0,        32'h0,        1'b1, 1, 0, 1'b1});
    tbl.push_back('{1'b1, 3'd4, 32'h100,      32'h000000FF, 32'h0,        1'b1, 1, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h80000100, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h10,       32'hABCDEF80, 32'h0,        1'b0, 2, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 4, 0, 1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h10,       32'h0,        32'h00000080, 1'b0, 4, 2, 1'b0});

    #1 rst_n = 1'b0;
    #2;
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_fault", 32'(resp_fault), 32'd0);
    check("reset mask", 32'(mem_write_mask), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset wdata", mem_write_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset req_ready", 32'(req_ready), 32'd1);

    foreach (tbl[i]) begin
      ref_model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_flt, m_rd, m_lat);
      xact($sformatf("vec%0d", i), tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
           tbl[i].exp_flt, tbl[i].exp_rd, tbl[i].exp_lat, tbl[i].hold, tbl[i].early);
    end

    // Reset arriving while the store mask is on the bus: the store must never land.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500; req_wdata = 32'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_store mask before", 32'(mem_write_mask), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("rst_store mask cleared", 32'(mem_write_mask), 32'd0);
    check("rst_store no resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_resp = any_resp | resp_valid | (mem_write_mask != 4'd0);
    end
    check("rst_store req_ready", 32'(req_ready), 32'd1);
    check("rst_store quiet after", 32'(any_resp), 32'd0);
    ref_model(1'b0, 3'd2, 32'h500, 32'h0, m_flt, m_rd, m_lat);
    xact("rst_store readback", 1'b0, 3'd2, 32'h500, 32'h0, m_flt, m_rd, m_lat, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'd0;
          1:       f3 = 3'd1;
          2:       f3 = 3'd2;
          3:       f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      case ($urandom_range(0, 9))
        0:       addr = 32'(MEMB - 8 + int'($urandom_range(0, 7)));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 63));
      endcase
      hold = int'($urandom_range(0, 2));
      req_wdata = $urandom;
      ref_model(wr, f3, addr, req_wdata, m_flt, m_rd, m_lat);
      xact($sformatf("rnd%0d", n), wr, f3, addr, req_wdata, m_flt, m_rd, m_lat, hold,
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
